// File: rtl/bubble_sequencer.sv
// In-place ascending unsigned bubble sort (with early exit) of scratch memory cells 0..len-1.
// The controller owns the memory port while busy and exposes a saturating swap counter.
module bubble_sequencer #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDRESS_WIDTH:0] len,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            swap_count,
    output logic                   mem_we,
    output logic [ADDRESS_WIDTH:0] mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_din,
    output logic                   mem_mode,
    input  logic [DATA_WIDTH-1:0]  mem_dout
);

    localparam int unsigned AW = ADDRESS_WIDTH + 1;
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CMP,
        WR_A,
        WR_B,
        DONE
    } state_t;

    state_t                state_q;
    logic [AW-1:0]         j_q;
    logic [AW-1:0]         limit_q;
    logic [AW-1:0]         len_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  swapped_q;
    logic [CW-1:0]         swap_count_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  mem_we_q;
    logic [AW-1:0]         mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_din_q;

    logic [AW-1:0] j_inc_c;
    logic          last_cmp_c;
    logic          swap_c;
    logic          advance_c;
    logic          finish_c;

    // Advance decision shared by the no-swap compare and the second write.
    always_comb begin
        j_inc_c    = j_q + AW'(1);
        last_cmp_c = (j_inc_c >= (limit_q - AW'(1)));
        swap_c     = (a_q > mem_dout);
        advance_c  = ((state_q == CMP) && !swap_c) || (state_q == WR_B);
        // A pass that just swapped (WR_B) can only finish when the unsorted window is 2.
        finish_c   = last_cmp_c &&
                     (((state_q == CMP) && !swapped_q) || (limit_q == AW'(2)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            j_q          <= '0;
            limit_q      <= '0;
            len_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            swapped_q    <= 1'b0;
            swap_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            done_q   <= 1'b0;
            mem_we_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q        <= len;
                        swap_count_q <= '0;
                        if (len < AW'(2)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            limit_q    <= len;
                            j_q        <= '0;
                            swapped_q  <= 1'b0;
                            state_q    <= RD_A;
                            busy_q     <= 1'b1;
                            mem_addr_q <= '0;
                        end
                    end
                end
                RD_A: begin
                    state_q    <= RD_B;
                    mem_addr_q <= j_inc_c;
                end
                RD_B: begin
                    a_q     <= mem_dout;
                    state_q <= CMP;
                end
                CMP: begin
                    b_q <= mem_dout;
                    if (swap_c) begin
                        state_q    <= WR_A;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= j_q;
                        mem_din_q  <= mem_dout;
                    end
                end
                WR_A: begin
                    state_q    <= WR_B;
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= j_inc_c;
                    mem_din_q  <= a_q;
                end
                WR_B: begin
                    swapped_q <= 1'b1;
                    if (swap_count_q != {CW{1'b1}}) begin
                        swap_count_q <= swap_count_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Next compare, next pass, or finish; overrides the per-state assignments above.
            if (advance_c) begin
                if (finish_c) begin
                    state_q    <= DONE;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    mem_addr_q <= '0;
                    mem_din_q  <= '0;
                end else if (last_cmp_c) begin
                    state_q    <= RD_A;
                    limit_q    <= limit_q - AW'(1);
                    j_q        <= '0;
                    swapped_q  <= 1'b0;
                    mem_addr_q <= '0;
                end else begin
                    state_q    <= RD_A;
                    j_q        <= j_inc_c;
                    mem_addr_q <= j_inc_c;
                end
            end
        end
    end

    // Structural invariants of the sort window and the swap write-back.
    a_window: assert property (@(posedge clk) disable iff (rst)
        busy_q |-> ((limit_q <= len_q) && (limit_q >= AW'(2))));
    a_swap_wr: assert property (@(posedge clk) disable iff (rst)
        (state_q == WR_A) |-> ((mem_din_q == b_q) && (a_q > b_q)));

    assign busy       = busy_q;
    assign done       = done_q;
    assign swap_count = swap_count_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_mode   = 1'b0;

endmodule

// File: tb/tb_bubble_sequencer.sv
// Randomized and directed bench for bubble_sequencer against an array-level bubble-sort model
// and a registered-read memory model.
module tb_bubble_sequencer;

    localparam int unsigned DW    = 32;
    localparam int unsigned AWP   = 6;
    localparam int unsigned AW    = AWP + 1;
    localparam int unsigned DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] len;
    logic          busy;
    logic          done;
    logic [15:0]   swap_count;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_mode;
    logic [DW-1:0] mem_dout;

    logic [DW-1:0] mem      [DEPTH];
    logic [DW-1:0] init_mem [DEPTH];
    logic [DW-1:0] exp_mem  [DEPTH];
    logic          load_req;

    int checks   = 0;
    int failures = 0;
    int exp_cmps;
    int exp_swaps;

    always #5 clk = ~clk;

    bubble_sequencer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AWP)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_mode   (mem_mode),
        .mem_dout   (mem_dout)
    );

    // Scratch memory: synchronous write, registered read of the presented address.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_mem[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
        mem_dout <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain bubble sort with early exit on the first n cells of exp_mem.
    task automatic model_sort(input int n);
        logic [DW-1:0] t;
        bit sw;
        exp_cmps  = 0;
        exp_swaps = 0;
        for (int lim = n; lim >= 2; lim--) begin
            sw = 1'b0;
            for (int k = 0; k < lim - 1; k++) begin
                exp_cmps++;
                if (exp_mem[k] > exp_mem[k+1]) begin
                    t            = exp_mem[k];
                    exp_mem[k]   = exp_mem[k+1];
                    exp_mem[k+1] = t;
                    sw           = 1'b1;
                    exp_swaps++;
                end
            end
            if (!sw) break;
        end
    endtask

    task automatic load_mem();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic run_sort(input int n, input bit noise, input string tag);
        int busy_cyc;
        int we_cnt;
        int bound;
        int mode_hi;
        logic [15:0] sc;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_mem[i];
        model_sort(n);
        load_mem();
        @(negedge clk);
        len   = AW'(n);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cyc = 0;
        we_cnt   = 0;
        bound    = 0;
        mode_hi  = 0;
        while (!done && bound < 20000) begin
            if (busy) busy_cyc++;
            if (mem_we) we_cnt++;
            if (mem_mode) mode_hi++;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                len   = AW'($urandom);
            end
            bound++;
            @(negedge clk);
        end
        start = 1'b0;
        check_eq($sformatf("%s done_seen", tag), done, 1'b1);
        check_eq($sformatf("%s busy_at_done", tag), busy, 1'b0);
        check_eq($sformatf("%s we_at_done", tag), mem_we, 1'b0);
        check_eq($sformatf("%s addr_at_done", tag), mem_addr, '0);
        check_eq($sformatf("%s busy_cycles", tag), busy_cyc, 3 * exp_cmps + 2 * exp_swaps);
        check_eq($sformatf("%s write_pulses", tag), we_cnt, 2 * exp_swaps);
        check_eq($sformatf("%s mode_high", tag), mode_hi, 0);
        check_eq($sformatf("%s swap_count", tag), swap_count, exp_swaps);
        sc = swap_count;
        @(negedge clk);
        check_eq($sformatf("%s done_pulse", tag), done, 1'b0);
        check_eq($sformatf("%s swap_hold", tag), swap_count, sc);
        for (int k = 0; k < n + 2 && k < DEPTH; k++)
            check_eq($sformatf("%s mem[%0d]", tag, k), mem[k], exp_mem[k]);
    endtask

    task automatic set4(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                        input logic [DW-1:0] v2, input logic [DW-1:0] v3);
        for (int i = 0; i < DEPTH; i++) init_mem[i] = DW'($urandom);
        init_mem[0] = v0;
        init_mem[1] = v1;
        init_mem[2] = v2;
        init_mem[3] = v3;
    endtask

    initial begin
        int n;
        int found;
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        load_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) init_mem[i] = '0;
        repeat (3) @(negedge clk);
        check_eq("rst busy", busy, 1'b0);
        check_eq("rst done", done, 1'b0);
        check_eq("rst swap_count", swap_count, '0);
        check_eq("rst mem_we", mem_we, 1'b0);
        check_eq("rst mem_addr", mem_addr, '0);
        check_eq("rst mem_din", mem_din, '0);
        check_eq("rst mem_mode", mem_mode, 1'b0);
        rst = 1'b0;

        set4(32'd1, 32'd2, 32'd3, 32'd4);
        run_sort(4, 1'b0, "sorted");
        set4(32'd3, 32'd1, 32'd2, 32'd99);
        run_sort(3, 1'b0, "three");
        set4(32'd4, 32'd3, 32'd2, 32'd1);
        run_sort(4, 1'b1, "reverse_noisy");
        set4(32'hFFFF_FFFF, 32'd1, 32'd5, 32'd5);
        run_sort(4, 1'b0, "unsigned");
        check_eq("unsigned swaps_is_3", swap_count, 16'd3);
        set4(32'd9, 32'd8, 32'd7, 32'd6);
        run_sort(0, 1'b1, "len0");
        run_sort(1, 1'b1, "len1");

        // Reset in the first write-back of a reverse sort.
        set4(32'd4, 32'd3, 32'd2, 32'd1);
        load_mem();
        @(negedge clk);
        len   = AW'(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            if (mem_we) found = 1;
            else @(negedge clk);
        end
        check_eq("rstmid found_wr_a", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstmid busy", busy, 1'b0);
        check_eq("rstmid done", done, 1'b0);
        check_eq("rstmid mem_we", mem_we, 1'b0);
        check_eq("rstmid mem_addr", mem_addr, '0);
        check_eq("rstmid swap_count", swap_count, '0);
        check_eq("rstmid mem0_written", mem[0], 32'd3);
        check_eq("rstmid mem1_kept", mem[1], 32'd3);
        rst = 1'b0;
        run_sort(4, 1'b0, "after_rst");

        for (int r = 0; r < 30; r++) begin
            n = int'($urandom_range(0, 20));
            for (int i = 0; i < DEPTH; i++)
                init_mem[i] = (r % 3 == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom);
            run_sort(n, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
